// File: rtl/alu_issue_arbiter_if.sv
// Bundles the request bus, the shared-ALU ports and the result bus of alu_issue_arbiter.
// The master side is the environment (requesters, ALU, consumer); the slave side is the arbiter.
interface alu_issue_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [4*NUM_REQ-1:0]  req_op;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;

  logic [3:0]            alu_op;
  logic [31:0]           alu_a;
  logic [31:0]           alu_b;
  logic [31:0]           alu_out;

  logic                  res_valid;
  logic                  res_ready;
  logic [31:0]           res_data;
  logic [ID_W-1:0]       res_id;
  logic                  res_err;
  logic                  busy;

  modport master (
    output req_valid, req_op, req_a, req_b,
    input  req_ready,
    input  alu_op, alu_a, alu_b,
    output alu_out,
    input  res_valid, res_data, res_id, res_err, busy,
    output res_ready
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    output req_ready,
    output alu_op, alu_a, alu_b,
    input  alu_out,
    output res_valid, res_data, res_id, res_err, busy,
    input  res_ready
  );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue of NUM_REQ requesters into one shared combinational ALU, with a
// registered issue stage (S1) and a tagged result stage (S2) behind a valid/ready port.
module alu_issue_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input logic                 clk,
  input logic                 rst,
  alu_issue_arbiter_if.slave  bus
);

  // Issue stage
  logic            s1_v;
  logic [3:0]      s1_op;
  logic [31:0]     s1_a;
  logic [31:0]     s1_b;
  logic [ID_W-1:0] s1_id;

  // Result stage
  logic            s2_v;
  logic [31:0]     s2_data;
  logic [ID_W-1:0] s2_id;
  logic            s2_err;

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] rr_ptr_d;

  logic            s2_adv;
  logic            s1_adv;
  logic            accept;
  logic            found;
  logic [ID_W-1:0] grant;
  int unsigned     idx;
  int unsigned     gsel;

  logic [3:0]      sel_op;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;

  function automatic logic op_illegal(input logic [3:0] op);
    return !((op <= 4'h6) || (op == 4'h8) || (op == 4'h9));
  endfunction

  always_comb begin
    s2_adv = !s2_v || bus.res_ready;
    s1_adv = !s1_v || s2_adv;
    accept = s1_adv && (|bus.req_valid);
  end

  // First valid requester at or above rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!found && bus.req_valid[idx[ID_W-1:0]]) begin
        grant = idx[ID_W-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    gsel   = 32'(grant);
    sel_op = bus.req_op[4*gsel +: 4];
    sel_a  = bus.req_a[32*gsel +: 32];
    sel_b  = bus.req_b[32*gsel +: 32];
  end

  always_comb begin
    bus.req_ready = '0;
    if (accept) begin
      bus.req_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr;
    if (accept) begin
      rr_ptr_d = (32'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else begin
      rr_ptr <= rr_ptr_d;
    end
  end

  // S1 payload is only written on accept so the ALU inputs stay quiet while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v  <= 1'b0;
      s1_op <= '0;
      s1_a  <= '0;
      s1_b  <= '0;
      s1_id <= '0;
    end else if (accept) begin
      s1_v  <= 1'b1;
      s1_op <= sel_op;
      s1_a  <= sel_a;
      s1_b  <= sel_b;
      s1_id <= grant;
    end else if (s1_adv) begin
      s1_v  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v    <= 1'b0;
      s2_data <= '0;
      s2_id   <= '0;
      s2_err  <= 1'b0;
    end else if (s1_v && s2_adv) begin
      s2_v    <= 1'b1;
      s2_data <= bus.alu_out;
      s2_id   <= s1_id;
      s2_err  <= op_illegal(s1_op);
    end else if (bus.res_ready) begin
      s2_v    <= 1'b0;
    end
  end

  always_comb begin
    bus.alu_op    = s1_op;
    bus.alu_a     = s1_a;
    bus.alu_b     = s1_b;
    bus.res_valid = s2_v;
    bus.res_data  = s2_data;
    bus.res_id    = s2_id;
    bus.res_err   = s2_err;
    bus.busy      = s1_v || s2_v;
  end

endmodule
